// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_W       = 14;
  localparam int unsigned DEFAULT_DATA_W       = 32;
  localparam int unsigned DEFAULT_MAX_LD_BURST = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_CPU_RD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of loader grants taken while the CPU is waiting.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_LD_BURST = DEFAULT_MAX_LD_BURST
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = (MAX_LD_BURST > 0) ? $clog2(MAX_LD_BURST + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q >= CNT_W'(MAX_LD_BURST));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data BRAM between the CPU load/store path and the
// UART loader; stalls the CPU for its two-cycle reads and bounds loader bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned MAX_LD_BURST = DEFAULT_MAX_LD_BURST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       starve_sat;

  arb_starve_counter #(
    .MAX_LD_BURST (MAX_LD_BURST)
  ) u_starve_counter (
    .clock (clock),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .sat   (starve_sat)
  );

  // Outputs are decoded combinationally; reset forces every output quiet.
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    ld_ack    = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    cnt_inc   = 1'b0;
    cnt_clr   = !cpu_req;

    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ld_req && !starve_sat) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            ld_ack    = 1'b1;
            cpu_stall = cpu_req;
            cnt_inc   = cpu_req;
          end else if (cpu_req) begin
            mem_en  = 1'b1;
            mem_we  = cpu_we;
            cnt_clr = 1'b1;
            if (!cpu_we) begin
              cpu_stall = 1'b1;
              state_d   = ST_CPU_RD;
            end
          end
        end
        ST_CPU_RD: begin
          // Read data returns now; the CPU still holds cpu_req but is not re-served.
          cpu_rdata = mem_rdata;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, starvation sequence, and
// randomized traffic checked against a memory-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 8;

  typedef struct {
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
  } stim_t;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic          ack;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MAX_LD_BURST (MAXB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_ack    (ld_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous single-port BRAM with a bench-side preload port.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clock) begin
    if (pre_we) begin
      bram[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;

  // Reference model: contents of memory plus an outstanding-read flag and a burst tally.
  logic [DW-1:0] shadow [int];
  int unsigned   burst;
  bit            rd_pend;
  logic [DW-1:0] rd_val;

  task automatic model_eval(input stim_t s, output exp_t e);
    e.en = 1'b0; e.we = 1'b0; e.stall = 1'b0; e.ack = 1'b0; e.rdata = '0;
    e.addr = s.cpu_addr; e.wdata = s.cpu_wdata;
    if (s.rst) begin
      rd_pend = 1'b0;
      burst   = 0;
    end else if (rd_pend) begin
      e.rdata = rd_val;
      rd_pend = 1'b0;
      if (!s.cpu_req) burst = 0;
    end else if (s.ld_req && burst < MAXB) begin
      e.en = 1'b1; e.we = 1'b1; e.ack = 1'b1; e.stall = s.cpu_req;
      e.addr = s.ld_addr; e.wdata = s.ld_wdata;
      shadow[int'(s.ld_addr)] = s.ld_wdata;
      if (s.cpu_req) burst = (burst + 1 > MAXB) ? MAXB : burst + 1;
      else           burst = 0;
    end else if (s.cpu_req) begin
      e.en = 1'b1; e.we = s.cpu_we;
      burst = 0;
      if (s.cpu_we) begin
        shadow[int'(s.cpu_addr)] = s.cpu_wdata;
      end else begin
        e.stall = 1'b1;
        rd_pend = 1'b1;
        rd_val  = shadow[int'(s.cpu_addr)];
      end
    end else begin
      burst = 0;
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clock);
    reset     = s.rst;
    cpu_req   = s.cpu_req;
    cpu_we    = s.cpu_we;
    cpu_addr  = s.cpu_addr;
    cpu_wdata = s.cpu_wdata;
    ld_req    = s.ld_req;
    ld_addr   = s.ld_addr;
    ld_wdata  = s.ld_wdata;
    #1;
  endtask

  task automatic chk1(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic check(input string tag, input int idx, input exp_t e);
    chk1($sformatf("%s[%0d] mem_en", tag, idx),    DW'(mem_en),    DW'(e.en));
    chk1($sformatf("%s[%0d] mem_we", tag, idx),    DW'(mem_we),    DW'(e.we));
    chk1($sformatf("%s[%0d] cpu_stall", tag, idx), DW'(cpu_stall), DW'(e.stall));
    chk1($sformatf("%s[%0d] ld_ack", tag, idx),    DW'(ld_ack),    DW'(e.ack));
    chk1($sformatf("%s[%0d] cpu_rdata", tag, idx), cpu_rdata,      e.rdata);
    if (e.en) chk1($sformatf("%s[%0d] mem_addr", tag, idx), DW'(mem_addr), DW'(e.addr));
    if (e.en && e.we) chk1($sformatf("%s[%0d] mem_wdata", tag, idx), mem_wdata, e.wdata);
  endtask

  function automatic vec_t mkv(
    input logic rst, input logic cr, input logic cw, input int ca, input logic [DW-1:0] cd,
    input logic lr, input int la, input logic [DW-1:0] ld,
    input logic en, input logic we, input int ea, input logic [DW-1:0] ed,
    input logic st, input logic ak, input logic [DW-1:0] rd);
    vec_t v;
    v.s.rst = rst; v.s.cpu_req = cr; v.s.cpu_we = cw; v.s.cpu_addr = AW'(ca); v.s.cpu_wdata = cd;
    v.s.ld_req = lr; v.s.ld_addr = AW'(la); v.s.ld_wdata = ld;
    v.e.en = en; v.e.we = we; v.e.addr = AW'(ea); v.e.wdata = ed;
    v.e.stall = st; v.e.ack = ak; v.e.rdata = rd;
    return v;
  endfunction

  vec_t  tbl[$];
  exp_t  mdl;
  stim_t rs;

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    burst = 0; rd_pend = 1'b0; rd_val = '0;

    repeat (2) @(negedge clock);
    for (int a = 0; a < 32; a++) begin
      @(negedge clock);
      pre_we   = 1'b1;
      pre_addr = AW'(a);
      pre_data = (a == 16) ? 32'hDEADBEEF : 32'h1000_0000 + DW'(a);
      shadow[a] = pre_data;
    end
    @(negedge clock);
    pre_we = 1'b0;

    // Directed vectors, one row per cycle.
    tbl.push_back(mkv(1, 0,0,0,0,               0,0,0,               0,0,0,0,               0,0,0));
    tbl.push_back(mkv(0, 0,0,0,0,               0,0,0,               0,0,0,0,               0,0,0));
    tbl.push_back(mkv(0, 1,0,'h010,0,           0,0,0,               1,0,'h010,0,           1,0,0));
    tbl.push_back(mkv(0, 1,0,'h010,0,           0,0,0,               0,0,0,0,               0,0,32'hDEADBEEF));
    tbl.push_back(mkv(0, 1,1,'h020,32'h12345678,0,0,0,               1,1,'h020,32'h12345678,0,0,0));
    tbl.push_back(mkv(0, 1,0,'h020,0,           0,0,0,               1,0,'h020,0,           1,0,0));
    tbl.push_back(mkv(0, 1,0,'h020,0,           0,0,0,               0,0,0,0,               0,0,32'h12345678));
    tbl.push_back(mkv(0, 1,1,'h030,32'h11,      1,'h005,32'hA5A5A5A5,1,1,'h005,32'hA5A5A5A5,1,1,0));
    tbl.push_back(mkv(0, 1,1,'h030,32'h11,      0,0,0,               1,1,'h030,32'h11,      0,0,0));
    tbl.push_back(mkv(0, 1,0,'h005,0,           0,0,0,               1,0,'h005,0,           1,0,0));
    tbl.push_back(mkv(0, 1,0,'h005,0,           1,'h006,32'h66,      0,0,0,0,               0,0,32'hA5A5A5A5));
    tbl.push_back(mkv(0, 0,0,0,0,               1,'h006,32'h66,      1,1,'h006,32'h66,      0,1,0));
    tbl.push_back(mkv(0, 0,0,0,0,               0,0,0,               0,0,0,0,               0,0,0));
    tbl.push_back(mkv(0, 1,0,'h006,0,           0,0,0,               1,0,'h006,0,           1,0,0));
    tbl.push_back(mkv(0, 1,0,'h006,0,           0,0,0,               0,0,0,0,               0,0,32'h66));
    tbl.push_back(mkv(0, 1,0,'h010,0,           0,0,0,               1,0,'h010,0,           1,0,0));
    tbl.push_back(mkv(1, 1,0,'h010,0,           0,0,0,               0,0,0,0,               0,0,0));
    tbl.push_back(mkv(0, 0,0,0,0,               0,0,0,               0,0,0,0,               0,0,0));
    tbl.push_back(mkv(0, 0,0,0,0,               0,0,0,               0,0,0,0,               0,0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].s);
      model_eval(tbl[i].s, mdl);
      check("vec", i, tbl[i].e);
    end

    // Starvation bound: MAXB loader acks, one CPU write, then the loader again.
    for (int i = 0; i < int'(MAXB) + 2; i++) begin
      vec_t v;
      if (i < int'(MAXB) || i == int'(MAXB) + 1)
        v = mkv(0, 1,1,'h040,32'h77, 1,'h100+i,32'hC000_0000+DW'(i),
                1,1,'h100+i,32'hC000_0000+DW'(i), 1,1,0);
      else
        v = mkv(0, 1,1,'h040,32'h77, 1,'h100+i,32'hC000_0000+DW'(i),
                1,1,'h040,32'h77, 0,0,0);
      drive(v.s);
      model_eval(v.s, mdl);
      check("starve", i, v.e);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned ld_pct;
      ld_pct       = ((i / 150) % 2 == 1) ? 95 : 40;
      rs.rst       = ($urandom_range(0, 99) == 0);
      rs.cpu_req   = ($urandom_range(0, 99) < 70);
      rs.cpu_we    = $urandom_range(0, 1) == 1;
      rs.cpu_addr  = AW'($urandom_range(0, 31));
      rs.cpu_wdata = $urandom;
      rs.ld_req    = ($urandom_range(0, 99) < ld_pct);
      rs.ld_addr   = AW'($urandom_range(0, 31));
      rs.ld_wdata  = $urandom;
      drive(rs);
      model_eval(rs, mdl);
      check("rand", i, mdl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port synchronous data-memory BRAM. It shares the memory between the CPU load/store path (MemRead/MemWrite traffic that is not I/O) and the UART program loader. It sequences the CPU's two-cycle BRAM reads with a stall. It also bounds loader bursts so that a pending CPU access is never starved.

## Interface
Parameters:
- ADDR_W, default 14: word-address width of the data BRAM.
- DATA_W, default 32: data width.
- MAX_LD_BURST, default 8: number of consecutive loader grants allowed while a CPU request waits.

Ports:
- clock, in, 1: the single clock. All state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- cpu_req, in, 1: CPU access request (MemRead | MemWrite).
- cpu_we, in, 1: 1 = CPU write, 0 = CPU read.
- cpu_addr, in, ADDR_W: CPU word address.
- cpu_wdata, in, DATA_W: CPU write data.
- cpu_rdata, out, DATA_W: CPU read data. Valid in the cycle cpu_stall falls after a read.
- cpu_stall, out, 1: freezes the CPU (PC and register write enable).
- ld_req, in, 1: loader write request. The loader is write-only.
- ld_addr, in, ADDR_W: loader word address.
- ld_wdata, in, DATA_W: loader write data.
- ld_ack, out, 1: single-cycle pulse meaning the loader write is committed at this clock edge.
- mem_en, out, 1: BRAM enable.
- mem_we, out, 1: BRAM write enable.
- mem_addr, out, ADDR_W: BRAM address.
- mem_wdata, out, DATA_W: BRAM write data.
- mem_rdata, in, DATA_W: BRAM read data, valid one cycle after a read issue.

## Operation
- States: IDLE and CPU_RD. Internal state also includes starve_cnt, which is wide enough to hold MAX_LD_BURST.
- Arbitration happens only in IDLE. The loader wins if ld_req=1 and starve_cnt < MAX_LD_BURST. Otherwise the CPU wins if cpu_req=1.
- Loader grant:
  - mem_en=1, mem_we=1, address and data come from the ld_* ports.
  - ld_ack=1 in the same cycle.
  - If cpu_req=1, cpu_stall=1.
- CPU write grant:
  - mem_en=1, mem_we=1, address and data come from the cpu_* ports.
  - cpu_stall=0, so the write completes in a single cycle.
- CPU read grant:
  - mem_en=1, mem_we=0, cpu_stall=1, next state CPU_RD.
- CPU_RD:
  - No BRAM issue: mem_en=0, and no loader grant, so ld_ack=0.
  - cpu_rdata = mem_rdata, cpu_stall=0, next state IDLE.
  - cpu_req is still high in this cycle because the CPU is frozen on the same instruction. The arbiter does not re-issue the read.
- starve_cnt:
  - Increments on each loader grant taken while cpu_req=1.
  - Clears on a CPU grant, and in any cycle with cpu_req=0.
  - Saturates at MAX_LD_BURST.
- No grant in IDLE: mem_en=0, mem_we=0, cpu_stall=0, ld_ack=0.
- mem_addr and mem_wdata are don't-care while mem_en=0. They are driven from the cpu_* ports.

## Timing
- During reset and in the cycle after it: state=IDLE, starve_cnt=0, mem_en=0, mem_we=0, ld_ack=0, cpu_stall=0, cpu_rdata=0.
- Latencies:
  - CPU write: 0 stall cycles.
  - CPU read: 1 stall cycle, with data in cycle N+1.
  - Loader write: ack in the same cycle as ld_req when granted.
- Simultaneous ld_req and cpu_req in IDLE: the loader wins until starve_cnt reaches MAX_LD_BURST, then the CPU wins exactly once and the count clears.
- ld_req during CPU_RD: held off one cycle. The loader must hold ld_req, ld_addr and ld_wdata until ld_ack.
- Reset asserted in CPU_RD: return to IDLE and discard the read. cpu_stall=0.
- All outputs are combinational from state and inputs, except cpu_rdata during reset, which is forced to 0. There are no combinational loops: mem_rdata feeds only cpu_rdata.

## Structure
- Package dmem_arb_pkg holds the state encoding (IDLE=1'b0, CPU_RD=1'b1) and the default MAX_LD_BURST.
- One sub-module, arb_starve_counter: a saturating counter with inc, clr and sat outputs, parameterised by MAX_LD_BURST. It is instantiated once.

## Test plan
- **CPU read.** After reset, cpu_req=1, cpu_we=0, cpu_addr=0x010, with BRAM preloaded to 0xDEADBEEF. Expect cpu_stall=1 at cycle 0 and 0 at cycle 1, and cpu_rdata=0xDEADBEEF at cycle 1. mem_en is asserted exactly once.
- **CPU write.** cpu_req=1, cpu_we=1, addr 0x020, data 0x12345678. Expect mem_we=1 for 1 cycle and no stall. A following read returns 0x12345678.
- **Loader priority.** ld_req=1 (addr 0x5, data 0xA5A5A5A5) together with a CPU write. Expect ld_ack=1 and cpu_stall=1 in that cycle, then the CPU write on the next cycle.
- **Starvation bound.** ld_req held high with MAX_LD_BURST=8 while cpu_req is high. Expect 8 ld_ack pulses, then one CPU grant with ld_ack=0, then the loader resumes.
- **Loader during CPU_RD.** ld_req rises during CPU_RD. Expect no ld_ack that cycle, then ld_ack the next cycle with the held data written.
- **Reset mid-read.** Reset asserted in CPU_RD. Expect state IDLE, all outputs at reset values, and no spurious BRAM access afterward.
